// File: rtl/load_addr_queue.sv
// load_addr_queue: load address-generation stage with a DEPTH-entry in-order
// buffer. Computes rs1 + sext(imm) and the byte mask at push time, tracks
// branch masks for in-place squash/resolve, and presents entries in order
// behind a backpressure handshake on both sides.
// Optional feature macro: LOAD_MISALIGN_CHECK_EN (flag misaligned/illegal
// accesses instead of forcing natural alignment).
module load_addr_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int BM_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  in_base,
  input  logic [11:0]      in_imm,
  input  logic [2:0]       in_funct3,
  input  logic [TAG_W-1:0] in_dest,
  input  logic [BM_W-1:0]  in_bm,
  output logic             in_backpressure,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_addr,
  output logic [3:0]       out_byte_mask,
  output logic             out_unsigned,
  output logic [TAG_W-1:0] out_dest,
  output logic [BM_W-1:0]  out_bm,
  output logic             out_misaligned,
  input  logic             out_backpressure,
  input  logic             squash_en,
  input  logic [BM_W-1:0]  squash_bm,
  input  logic             resolve_en,
  input  logic [BM_W-1:0]  resolve_bm
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Control state
  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_valid [DEPTH];

  // Payload storage
  logic [XLEN-1:0]  r_addr     [DEPTH];
  logic [3:0]       r_mask     [DEPTH];
  logic             r_unsigned [DEPTH];
  logic [TAG_W-1:0] r_dest     [DEPTH];
  logic [BM_W-1:0]  r_bm       [DEPTH];
  logic             r_misal    [DEPTH];

  logic             w_full, w_push, w_push_squashed;
  logic             w_head_present, w_head_valid, w_pop, w_discard, w_deq;
  logic [CNT_W-1:0] w_count_next;
  logic [BM_W-1:0]  w_push_bm;
  logic [XLEN-1:0]  w_raw_addr, w_addr;
  logic [3:0]       w_mask;
  logic             w_misal, w_illegal;
  logic [1:0]       w_size;

  assign w_full          = (r_count == FULL_CNT);
  assign w_push_squashed = squash_en & (|(in_bm & squash_bm));
  assign w_push          = in_valid & ~w_full & ~w_push_squashed;
  assign w_push_bm       = resolve_en ? (in_bm & ~resolve_bm) : in_bm;

  assign w_head_present  = (r_count != '0);
  assign w_head_valid    = w_head_present & r_valid[r_head];
  assign w_pop           = w_head_valid & ~out_backpressure;
  // A squashed head is dropped regardless of downstream stall.
  assign w_discard       = w_head_present & ~r_valid[r_head];
  assign w_deq           = w_pop | w_discard;

  assign w_raw_addr = in_base + {{(XLEN-12){in_imm[11]}}, in_imm};
  assign w_size     = in_funct3[1:0];
  assign w_illegal  = (in_funct3[1:0] == 2'b11) | (in_funct3[2] & in_funct3[1]);

  // Effective address, byte mask and misalignment flag for the incoming load
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    w_addr  = w_raw_addr;
    w_mask  = 4'b0000;
    w_misal = 1'b0;
`ifdef LOAD_MISALIGN_CHECK_EN
    w_misal = w_illegal
            | ((w_size == 2'd1) & w_raw_addr[0])
            | ((w_size == 2'd2) & (w_raw_addr[1:0] != 2'b00));
    if (!w_misal) begin
      case (w_size)
        2'd0:    w_mask = 4'b0001 << w_raw_addr[1:0];
        2'd1:    w_mask = 4'b0011 << w_raw_addr[1:0];
        2'd2:    w_mask = 4'b1111;
        default: w_mask = 4'b0000;
      endcase
    end
`else
    if (!w_illegal) begin
      case (w_size)
        2'd0: w_mask = 4'b0001 << w_raw_addr[1:0];
        2'd1: begin
          w_addr[0] = 1'b0;
          w_mask    = 4'b0011 << {w_raw_addr[1], 1'b0};
        end
        2'd2: begin
          w_addr[1:0] = 2'b00;
          w_mask      = 4'b1111;
        end
        default: w_mask = 4'b0000;
      endcase
    end
`endif
  end

  // Occupancy count next value
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_deq})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Pointers, count and valid bits (squash clears, push sets)
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only; the later
    // push write to the tail slot intentionally overrides the squash clear.
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_valid[i] <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash_en && (|(r_bm[i] & squash_bm))) r_valid[i] <= 1'b0;
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_deq) r_head <= r_head + 1'b1;
      r_count <= w_count_next;
    end
  end

  // Payload write on push and branch-mask resolve on stored entries
  always_ff @(posedge clock) begin
    // NOTE: payload arrays have no reset; r_valid and r_count gate every use.
    for (int i = 0; i < DEPTH; i++) begin
      if (resolve_en) r_bm[i] <= r_bm[i] & ~resolve_bm;
    end
    if (w_push) begin
      r_addr[r_tail]     <= w_addr;
      r_mask[r_tail]     <= w_mask;
      r_unsigned[r_tail] <= in_funct3[2];
      r_dest[r_tail]     <= in_dest;
      r_bm[r_tail]       <= w_push_bm;
      r_misal[r_tail]    <= w_misal;
    end
  end

  assign in_backpressure = w_full;
  assign out_valid       = w_head_valid;
  assign out_addr        = w_head_valid ? r_addr[r_head]     : '0;
  assign out_byte_mask   = w_head_valid ? r_mask[r_head]     : '0;
  assign out_unsigned    = w_head_valid ? r_unsigned[r_head] : 1'b0;
  assign out_dest        = w_head_valid ? r_dest[r_head]     : '0;
  assign out_bm          = w_head_valid ? r_bm[r_head]       : '0;
  assign out_misaligned  = w_head_valid ? r_misal[r_head]    : 1'b0;

endmodule
